// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave with programmable wait states and Stall generation.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned requests with RspErr instead of ignoring ReqAddr[1:0].
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              ReqValid,
   input  logic              ReqWrite,
   input  logic [ADDR_W-1:0] ReqAddr,
   input  logic [31:0]       ReqWData,
   input  logic [3:0]        ReqByteEn,
   output logic              ReqReady,
   output logic              RspValid,
   output logic [31:0]       RspRData,
   output logic              RspErr,
   output logic              Stall
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             state_q;
   logic [3:0]         cnt_q;
   logic               wr_q;
   logic               mis_q;
   logic [IDX_W-1:0]   idx_q;
   logic [31:0]        wdata_q;
   logic [3:0]         be_q;
   logic               ready_q;
   logic               rvalid_q;
   logic               err_q;
   logic [31:0]        rdata_q;
   logic [31:0]        mem_q [DEPTH_WORDS];

   logic               req_mis_s;
   logic [IDX_W-1:0]   req_idx_s;
   logic               commit_s;
   logic               c_wr_s;
   logic               c_mis_s;
   logic [IDX_W-1:0]   c_idx_s;
   logic [31:0]        c_wdata_s;
   logic [3:0]         c_be_s;
   logic               unused_addr_s;

   // High address bits wrap silently onto the array.
   assign req_idx_s     = ReqAddr[IDX_W+1:2];
   assign unused_addr_s = ^{ReqAddr[ADDR_W-1:IDX_W+2], ReqAddr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
   assign req_mis_s = (ReqAddr[1:0] != 2'b00);
`else
   assign req_mis_s = 1'b0;
`endif

   // Commit happens on the edge entering RESP; with zero wait states that is the accepting edge,
   // so the live request fields are used instead of the latched copy.
   always_comb begin
      commit_s  = 1'b0;
      c_wr_s    = wr_q;
      c_mis_s   = mis_q;
      c_idx_s   = idx_q;
      c_wdata_s = wdata_q;
      c_be_s    = be_q;
      case (state_q)
         S_IDLE: begin
            c_wr_s    = ReqWrite;
            c_mis_s   = req_mis_s;
            c_idx_s   = req_idx_s;
            c_wdata_s = ReqWData;
            c_be_s    = ReqByteEn;
            if (ReqValid && (WAIT_CYCLES == 0)) begin
               commit_s = 1'b1;
            end else begin
               commit_s = 1'b0;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               commit_s = 1'b1;
            end else begin
               commit_s = 1'b0;
            end
         end
         default: commit_s = 1'b0;
      endcase
   end

   // Request FSM with registered handshake and response outputs.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
         wr_q     <= 1'b0;
         mis_q    <= 1'b0;
         idx_q    <= {IDX_W{1'b0}};
         wdata_q  <= 32'd0;
         be_q     <= 4'd0;
      end else begin
         rvalid_q <= 1'b0;
         if (commit_s) begin
            rdata_q  <= (c_wr_s || c_mis_s) ? 32'd0 : mem_q[c_idx_s];
            err_q    <= c_mis_s;
            rvalid_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (ReqValid) begin
                  wr_q    <= ReqWrite;
                  mis_q   <= req_mis_s;
                  idx_q   <= req_idx_s;
                  wdata_q <= ReqWData;
                  be_q    <= ReqByteEn;
                  ready_q <= 1'b0;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= S_RESP;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= WAIT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Byte-lane store into the array; an access interrupted by reset never lands.
   always_ff @(posedge Clk) begin
      if (commit_s && c_wr_s && !c_mis_s && !Reset) begin
         for (int i = 0; i < 4; i++) begin
            if (c_be_s[i]) begin
               mem_q[c_idx_s][8*i +: 8] <= c_wdata_s[8*i +: 8];
            end
         end
      end
   end

   assign ReqReady = ready_q;
   assign RspValid = rvalid_q;
   assign RspRData = rdata_q;
   assign RspErr   = err_q;
   assign Stall    = ReqValid & ~rvalid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a 2-wait-state and a 0-wait-state instance against a word-array model.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        va = 1'b0;
   logic        vb = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wd = 32'd0;
   logic [3:0]  be = 4'd0;
   logic        rdy_a, rv_a, err_a, st_a;
   logic        rdy_b, rv_b, err_b, st_b;
   logic [31:0] rd_a, rd_b;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] mdl [2][1024];
   logic [31:0] last_rd [2];
   int          pool [8] = '{0, 1, 4, 16, 100, 511, 512, 1023};

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(1024), .ADDR_W(32), .WAIT_CYCLES(2)) u_dut_a (
      .Clk(clk), .Reset(rst), .ReqValid(va), .ReqWrite(wr), .ReqAddr(addr), .ReqWData(wd),
      .ReqByteEn(be), .ReqReady(rdy_a), .RspValid(rv_a), .RspRData(rd_a), .RspErr(err_a), .Stall(st_a)
   );

   dmem_responder #(.DEPTH_WORDS(1024), .ADDR_W(32), .WAIT_CYCLES(0)) u_dut_b (
      .Clk(clk), .Reset(rst), .ReqValid(vb), .ReqWrite(wr), .ReqAddr(addr), .ReqWData(wd),
      .ReqByteEn(be), .ReqReady(rdy_b), .RspValid(rv_b), .RspRData(rd_b), .RspErr(err_b), .Stall(st_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input int sel, input string tag, input logic rdy, input logic rv, input logic st);
      chk({tag, "_ready"}, (sel == 0) ? rdy_a : rdy_b, rdy);
      chk({tag, "_rspvalid"}, (sel == 0) ? rv_a : rv_b, rv);
      chk({tag, "_stall"}, (sel == 0) ? st_a : st_b, st);
   endtask

   // One full request/response; the model decides data, error and the cycle of the response.
   task automatic txn(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input bit flush);
      int          wc;
      int          idx;
      logic        mis;
      logic        vld;
      logic [31:0] exp_rd;
      wc  = (sel == 0) ? 2 : 0;
      idx = int'(a[11:2]);
      mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      mis = (a[1:0] != 2'b00);
`endif
      if (w) begin
         exp_rd = 32'd0;
         if (!mis) begin
            for (int i = 0; i < 4; i++) begin
               if (b[i]) mdl[sel][idx][8*i +: 8] = d[8*i +: 8];
            end
         end
      end else begin
         exp_rd = mis ? 32'd0 : mdl[sel][idx];
      end
      @(negedge clk);
      wr = w; addr = a; wd = d; be = b;
      if (sel == 0) va = 1'b1; else vb = 1'b1;
      vld = 1'b1;
      #1;
      chk_outs(sel, "idle", 1'b1, 1'b0, 1'b1);
      chk("rdata_hold", (sel == 0) ? rd_a : rd_b, last_rd[sel]);
      for (int k = 1; k <= wc + 1; k++) begin
         @(negedge clk);
         if (flush && k == 1 && wc > 0) begin
            va  = 1'b0;
            vld = 1'b0;
         end
         #1;
         if (k <= wc) begin
            chk_outs(sel, "wait", 1'b0, 1'b0, vld);
         end else begin
            chk_outs(sel, "resp", 1'b0, 1'b1, 1'b0);
            chk("rdata", (sel == 0) ? rd_a : rd_b, exp_rd);
            chk("rsperr", (sel == 0) ? err_a : err_b, {31'd0, mis});
         end
      end
      va = 1'b0;
      vb = 1'b0;
      last_rd[sel] = exp_rd;
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         last_rd[s] = 32'd0;
         for (int i = 0; i < 1024; i++) mdl[s][i] = 32'd0;
      end
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk_outs(s, "reset", 1'b1, 1'b0, 1'b0);
         chk("reset_rdata", (s == 0) ? rd_a : rd_b, 32'd0);
         chk("reset_err", (s == 0) ? err_a : err_b, 32'd0);
      end
      rst = 1'b0;

      // Give every pool word a known value in both instances.
      for (int s = 0; s < 2; s++) begin
         for (int p = 0; p < 8; p++) txn(s, 1'b1, 32'(pool[p]) << 2, $urandom, 4'hF, 1'b0);
      end

      txn(0, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0);
      txn(0, 1'b0, 32'h40, 32'd0, 4'h0, 1'b0);
      txn(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 1'b0);
      txn(0, 1'b0, 32'h40, 32'd0, 4'hF, 1'b0);
      chk("lane_merge_model", mdl[0][16], 32'h12BB56DD);
      txn(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 1'b0);
      txn(0, 1'b0, 32'h40, 32'd0, 4'h0, 1'b0);
      txn(0, 1'b1, 32'h1000, 32'h55, 4'hF, 1'b0);
      txn(0, 1'b0, 32'h0, 32'd0, 4'h0, 1'b0);
      txn(0, 1'b1, 32'h42, 32'h99999999, 4'hF, 1'b0);
      txn(0, 1'b0, 32'h40, 32'd0, 4'h0, 1'b0);
      txn(0, 1'b0, 32'h40, 32'd0, 4'h0, 1'b1);

      // Reset during WAIT drops the pending store.
      @(negedge clk);
      wr = 1'b1; addr = 32'h10; wd = 32'hDEADBEEF; be = 4'hF; va = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_outs(0, "midreset", 1'b1, 1'b0, 1'b1);
      chk("midreset_rdata", rd_a, 32'd0);
      chk("midreset_err", err_a, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      va = 1'b0;
      last_rd[0] = 32'd0;
      last_rd[1] = 32'd0;
      txn(0, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0);

      for (int n = 0; n < 80; n++) begin
         int          s;
         logic [31:0] a;
         s = int'($urandom_range(0, 1));
         a = {$urandom_range(0, 1048575) % 32'h100000, 10'(pool[$urandom_range(0, 7)]), 2'($urandom_range(0, 3))};
         txn(s, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      // Zero-wait instance: back-to-back loads give a response every second cycle.
      for (int n = 0; n < 6; n++) txn(1, 1'b0, 32'(pool[n]) << 2, 32'd0, 4'hF, 1'b0);

      @(negedge clk);
      #1;
      chk_outs(0, "final", 1'b1, 1'b0, 1'b0);
      chk_outs(1, "final", 1'b1, 1'b0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
